alu_multiciclo: RTL and testbench

ALU_MULTICICLO -- requirements
Module: alu_multiciclo

---
 rtl/alu_multiciclo_pkg.sv | 19 +
 rtl/alu_iterativo.sv | 88 ++++++++
 rtl/alu_multiciclo.sv | 137 +++++++++++++
 tb/tb_alu_multiciclo.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/alu_multiciclo_pkg.sv
// rtl/alu_multiciclo_pkg.sv - shared opcodes and FSM states for alu_multiciclo (OP_DIV is live only with ALU_DIV_EN)
package alu_multiciclo_pkg;

  localparam logic [4:0] OP_NOT = 5'd0;
  localparam logic [4:0] OP_AND = 5'd1;
  localparam logic [4:0] OP_OR  = 5'd2;
  localparam logic [4:0] OP_NEG = 5'd3;
  localparam logic [4:0] OP_ADD = 5'd4;
  localparam logic [4:0] OP_SUB = 5'd5;
  localparam logic [4:0] OP_MUL = 5'd6;
  localparam logic [4:0] OP_DIV = 5'd7;

  typedef enum logic [1:0] {
    ESPERA = 2'd0,
    ITERA  = 2'd1,
    FIN    = 2'd2
  } estado_t;

endpackage

// File: rtl/alu_iterativo.sv
// rtl/alu_iterativo.sv - shared shift register/accumulator: shift-add MUL and, with ALU_DIV_EN, restoring DIV
module alu_iterativo
  import alu_multiciclo_pkg::*;
#(
  parameter int BITS_DATA = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cargar,
  input  logic                 paso,
`ifdef ALU_DIV_EN
  input  logic                 es_div,
`endif
  input  logic [BITS_DATA-1:0] a,
  input  logic [BITS_DATA-1:0] b,
  output logic                 ultimo,
  output logic [BITS_DATA-1:0] res,
  output logic                 c,
  output logic                 o
);

  localparam int CW = $clog2(BITS_DATA);

  logic [BITS_DATA-1:0] acc_q, q_q, m_q, acc_d, q_d, sumando;
  logic [BITS_DATA:0]   suma;
  logic [CW-1:0]        cuenta_q;
`ifdef ALU_DIV_EN
  logic                 div_q;
  logic [BITS_DATA:0]   desplazado;
`endif

  // acc:q is one double-width register; MUL shifts right, DIV shifts left
  always_comb begin
    sumando = q_q[0] ? m_q : '0;
    suma    = {1'b0, acc_q} + {1'b0, sumando};
    acc_d   = suma[BITS_DATA:1];
    q_d     = {suma[0], q_q[BITS_DATA-1:1]};
`ifdef ALU_DIV_EN
    desplazado = {acc_q, q_q[BITS_DATA-1]};
    if (div_q) begin
      if (desplazado >= {1'b0, m_q}) begin
        acc_d = BITS_DATA'(desplazado - {1'b0, m_q});
        q_d   = {q_q[BITS_DATA-2:0], 1'b1};
      end else begin
        acc_d = desplazado[BITS_DATA-1:0];
        q_d   = {q_q[BITS_DATA-2:0], 1'b0};
      end
    end
`endif
  end

  assign ultimo = (cuenta_q == CW'(BITS_DATA - 1));
  assign res    = q_d;
  assign c      = (acc_d != '0);
`ifdef ALU_DIV_EN
  assign o      = div_q ? 1'b0 : c;
`else
  assign o      = c;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q    <= '0;
      q_q      <= '0;
      m_q      <= '0;
      cuenta_q <= '0;
`ifdef ALU_DIV_EN
      div_q    <= 1'b0;
`endif
    end else if (cargar) begin
      acc_q    <= '0;
      cuenta_q <= '0;
`ifdef ALU_DIV_EN
      div_q    <= es_div;
      q_q      <= es_div ? a : b;
      m_q      <= es_div ? b : a;
`else
      q_q      <= b;
      m_q      <= a;
`endif
    end else if (paso) begin
      acc_q    <= acc_d;
      q_q      <= q_d;
      cuenta_q <= cuenta_q + CW'(1);
    end
  end

endmodule

// File: rtl/alu_multiciclo.sv
// rtl/alu_multiciclo.sv - multicycle ALU top: FSM, single-step ops, result/flag registers; ALU_DIV_EN enables OP_DIV
module alu_multiciclo
  import alu_multiciclo_pkg::*;
#(
  parameter int BITS_DATA = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inicio,
  input  logic [4:0]           opcode,
  input  logic [BITS_DATA-1:0] operando_a,
  input  logic [BITS_DATA-1:0] operando_b,
  output logic                 ocupado,
  output logic                 listo,
  output logic [BITS_DATA-1:0] resultado,
  output logic                 C,
  output logic                 S,
  output logic                 O,
  output logic                 Z,
  output logic                 error
);

  localparam int MSB = BITS_DATA - 1;
  localparam logic [BITS_DATA-1:0] MAS_NEGATIVO = {1'b1, {(BITS_DATA-1){1'b0}}};

  estado_t              estado_q, estado_d;
  logic                 acepta, iterativo, ultimo, it_c, it_o;
  logic [BITS_DATA-1:0] it_res, res_uno;
  logic                 c_uno, o_uno, err_uno;
  logic [BITS_DATA:0]   suma_ext;

  assign acepta = inicio && (estado_q == ESPERA);
`ifdef ALU_DIV_EN
  // division by zero is resolved in one step, so it never enters ITERA
  assign iterativo = (opcode == OP_MUL) || ((opcode == OP_DIV) && (operando_b != '0));
`else
  assign iterativo = (opcode == OP_MUL);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) estado_q <= ESPERA;
    else       estado_q <= estado_d;
  end

  always_comb begin
    estado_d = estado_q;
    ocupado  = 1'b0;
    listo    = 1'b0;
    case (estado_q)
      ESPERA: if (inicio) estado_d = iterativo ? ITERA : FIN;
      ITERA: begin
        ocupado = 1'b1;
        if (ultimo) estado_d = FIN;
      end
      FIN: begin
        ocupado  = 1'b1;
        listo    = 1'b1;
        estado_d = ESPERA;
      end
      default: estado_d = ESPERA;
    endcase
  end

  always_comb begin
    res_uno  = '0;
    c_uno    = 1'b0;
    o_uno    = 1'b0;
    err_uno  = 1'b0;
    suma_ext = '0;
    case (opcode)
      OP_NOT: res_uno = ~operando_a;
      OP_AND: res_uno = operando_a & operando_b;
      OP_OR:  res_uno = operando_a | operando_b;
      OP_NEG: begin
        res_uno = '0 - operando_a;
        o_uno   = (operando_a == MAS_NEGATIVO);
      end
      OP_ADD: begin
        suma_ext = {1'b0, operando_a} + {1'b0, operando_b};
        res_uno  = suma_ext[BITS_DATA-1:0];
        c_uno    = suma_ext[BITS_DATA];
        o_uno    = (operando_a[MSB] == operando_b[MSB]) && (res_uno[MSB] != operando_a[MSB]);
      end
      OP_SUB: begin
        res_uno = operando_a - operando_b;
        c_uno   = (operando_a < operando_b);
        o_uno   = (operando_a[MSB] != operando_b[MSB]) && (res_uno[MSB] != operando_a[MSB]);
      end
`ifdef ALU_DIV_EN
      OP_DIV: begin
        res_uno = '1;
        o_uno   = 1'b1;
      end
`endif
      default: err_uno = 1'b1;
    endcase
  end

  alu_iterativo #(.BITS_DATA(BITS_DATA)) u_iterativo (
    .clk    (clk),
    .reset  (reset),
    .cargar (acepta && iterativo),
    .paso   (estado_q == ITERA),
`ifdef ALU_DIV_EN
    .es_div (opcode == OP_DIV),
`endif
    .a      (operando_a),
    .b      (operando_b),
    .ultimo (ultimo),
    .res    (it_res),
    .c      (it_c),
    .o      (it_o)
  );

  // results are captured on the edge that enters FIN and held until the next one
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resultado <= '0;
      {C, S, O, Z, error} <= '0;
    end else if (acepta && !iterativo) begin
      resultado <= res_uno;
      C         <= c_uno;
      O         <= o_uno;
      S         <= !err_uno && res_uno[MSB];
      Z         <= !err_uno && (res_uno == '0);
      error     <= err_uno;
    end else if ((estado_q == ITERA) && ultimo) begin
      resultado <= it_res;
      C         <= it_c;
      O         <= it_o;
      S         <= it_res[MSB];
      Z         <= (it_res == '0);
      error     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_multiciclo.sv
// tb/tb_alu_multiciclo.sv - self-checking bench for alu_multiciclo (BITS_DATA=32, honours ALU_DIV_EN)
module tb_alu_multiciclo;
  import alu_multiciclo_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         inicio = 1'b0;
  logic [4:0]   opcode = '0;
  logic [W-1:0] operando_a = '0, operando_b = '0;
  logic         ocupado, listo, c_f, s_f, o_f, z_f, error;
  logic [W-1:0] resultado;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_multiciclo #(.BITS_DATA(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .inicio     (inicio),
    .opcode     (opcode),
    .operando_a (operando_a),
    .operando_b (operando_b),
    .ocupado    (ocupado),
    .listo      (listo),
    .resultado  (resultado),
    .C          (c_f),
    .S          (s_f),
    .O          (o_f),
    .Z          (z_f),
    .error      (error)
  );

  // Reference model from the arithmetic definitions; packs {res,C,S,O,Z,err}
  task automatic ref_model(input logic [4:0] op, input logic [W-1:0] a, b,
                           output logic [W+4:0] exp_out, output int exp_lat);
    longint unsigned ua, ub, full;
    longint          sa, sb, sr;
    logic [W-1:0]    r;
    logic            c, o, e, s, z;
    ua = 64'(a); ub = 64'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    r = '0; c = 0; o = 0; e = 0; exp_lat = 1; full = 0; sr = 0;
    case (op)
      OP_NOT: r = ~a;
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_NEG: begin sr = -sa; r = sr[W-1:0]; o = (sr > 64'sd2147483647); end
      OP_ADD: begin
        full = ua + ub; r = full[W-1:0]; c = full[W];
        sr = sa + sb; o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      OP_SUB: begin
        r = a - b; c = (ua < ub);
        sr = sa - sb; o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      OP_MUL: begin
        full = ua * ub; r = full[W-1:0]; c = (full[63:32] != 0); o = c; exp_lat = W + 1;
      end
`ifdef ALU_DIV_EN
      OP_DIV: begin
        if (b == 0) begin r = '1; o = 1; end
        else begin r = a / b; c = ((a % b) != 0); exp_lat = W + 1; end
      end
`endif
      default: e = 1;
    endcase
    s = !e && r[W-1];
    z = !e && (r == 0);
    exp_out = {r, c, s, o, z, e};
  endtask

  // Drives one request and returns edges until listo; optionally scrambles inputs and pulses inicio mid-operation
  task automatic do_op(input logic [4:0] op, input logic [W-1:0] a, b, input bit disturb, output int lat);
    @(negedge clk);
    inicio = 1; opcode = op; operando_a = a; operando_b = b;
    lat = 0;
    do begin
      @(posedge clk); @(negedge clk); lat++;
      inicio = 0;
      if (disturb) begin
        operando_a = $urandom; operando_b = $urandom; opcode = OP_ADD;
        if (lat == 5) inicio = 1;
      end
    end while (!listo && lat < 100);
    inicio = 0;
  endtask

  function automatic logic [W+4:0] obs();
    return {resultado, c_f, s_f, o_f, z_f, error};
  endfunction

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({ocupado, listo, obs()} !== '0) begin
      n_bad++; $display("FAIL reset_state: got %h want 0", {ocupado, listo, obs()});
    end
    @(negedge clk); reset = 0;
  endtask

  task automatic test_directed();
    int lat;
    do_op(OP_ADD, 32'h7FFFFFFF, 32'h1, 0, lat);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL add_lat: got %0d want 1", lat); end
    n_cmp++; if (obs() !== {32'h80000000, 5'b01100}) begin n_bad++; $display("FAIL add_ovf: got %h want %h", obs(), {32'h80000000, 5'b01100}); end
    do_op(OP_SUB, 32'h5, 32'h7, 0, lat);
    n_cmp++; if (obs() !== {32'hFFFFFFFE, 5'b11000}) begin n_bad++; $display("FAIL sub_borrow: got %h want %h", obs(), {32'hFFFFFFFE, 5'b11000}); end
    do_op(OP_MUL, 32'h00010000, 32'h00010000, 1, lat);
    n_cmp++; if (lat !== W + 1) begin n_bad++; $display("FAIL mul_lat: got %0d want %0d", lat, W + 1); end
    n_cmp++; if (obs() !== {32'h0, 5'b10110}) begin n_bad++; $display("FAIL mul_hi: got %h want %h", obs(), {32'h0, 5'b10110}); end
    @(negedge clk);
    n_cmp++; if ({listo, ocupado} !== 2'b00) begin n_bad++; $display("FAIL mul_ignore_inicio: got %b want 00", {listo, ocupado}); end
`ifdef ALU_DIV_EN
    do_op(OP_DIV, 32'd100, 32'd7, 0, lat);
    n_cmp++; if ({lat, obs()} !== {W + 1, 32'd14, 5'b10000}) begin n_bad++; $display("FAIL div_100_7: lat %0d got %h", lat, obs()); end
    do_op(OP_DIV, 32'd1234, 32'd0, 0, lat);
    n_cmp++; if ({lat, obs()} !== {32'd1, 32'hFFFFFFFF, 5'b01100}) begin n_bad++; $display("FAIL div_zero: lat %0d got %h", lat, obs()); end
`else
    do_op(OP_DIV, 32'd100, 32'd7, 0, lat);
    n_cmp++; if ({lat, obs()} !== {32'd1, 32'd0, 5'b00001}) begin n_bad++; $display("FAIL div_disabled: lat %0d got %h", lat, obs()); end
`endif
    do_op(5'b11111, 32'h1234, 32'h5678, 0, lat);
    n_cmp++; if (obs() !== {32'h0, 5'b00001}) begin n_bad++; $display("FAIL bad_opcode: got %h want %h", obs(), {32'h0, 5'b00001}); end
    do_op(OP_AND, 32'hF0F0F0F0, 32'h0F0F0F0F, 0, lat);
    n_cmp++; if (obs() !== {32'h0, 5'b00010}) begin n_bad++; $display("FAIL and_zero: got %h want %h", obs(), {32'h0, 5'b00010}); end
  endtask

  task automatic test_reset_abort();
    int lat;
    bit seen;
    do_op(OP_ADD, 32'd1, 32'd1, 0, lat);
    @(negedge clk);
    inicio = 1; opcode = OP_MUL; operando_a = 32'd3; operando_b = 32'd5;
    @(posedge clk); @(negedge clk); inicio = 0;
    repeat (10) @(posedge clk);
    @(negedge clk); reset = 1; #1;
    n_cmp++; if ({ocupado, listo, obs()} !== '0) begin n_bad++; $display("FAIL abort_async: got %h want 0", {ocupado, listo, obs()}); end
    @(negedge clk); reset = 0;
    seen = 0;
    repeat (W + 4) begin @(negedge clk); seen |= listo; end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_no_listo: got %b want 0", seen); end
    do_op(OP_ADD, 32'd2, 32'd3, 0, lat);
    n_cmp++; if ({lat, obs()} !== {32'd1, 32'd5, 5'b00000}) begin n_bad++; $display("FAIL abort_next_add: lat %0d got %h", lat, obs()); end
  endtask

  task automatic test_back_to_back();
    logic [W+4:0] exp_out;
    int           exp_lat;
    logic [4:0]   ops [6] = '{OP_ADD, OP_SUB, OP_NOT, OP_OR, OP_NEG, OP_AND};
    @(negedge clk);
    inicio = 1; opcode = ops[0]; operando_a = $urandom; operando_b = $urandom;
    for (int i = 0; i < 6; i++) begin
      ref_model(opcode, operando_a, operando_b, exp_out, exp_lat);
      @(posedge clk); @(negedge clk);
      n_cmp++; if ({listo, obs()} !== {1'b1, exp_out}) begin n_bad++; $display("FAIL b2b_done[%0d]: got %b/%h want 1/%h", i, listo, obs(), exp_out); end
      opcode = ops[(i + 1) % 6]; operando_a = $urandom; operando_b = $urandom;
      @(posedge clk); @(negedge clk);
      n_cmp++; if ({listo, ocupado, obs()} !== {2'b00, exp_out}) begin n_bad++; $display("FAIL b2b_hold[%0d]: got %b%b/%h want 00/%h", i, listo, ocupado, obs(), exp_out); end
    end
    inicio = 0;
  endtask

  task automatic test_random();
    logic [4:0]   ops [9] = '{OP_NOT, OP_AND, OP_OR, OP_NEG, OP_ADD, OP_SUB, OP_MUL, OP_DIV, 5'd20};
    logic [W-1:0] esp [5] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    logic [W+4:0] exp_out;
    logic [W-1:0] a, b;
    logic [4:0]   op;
    int           exp_lat, lat;
    for (int i = 0; i < 60; i++) begin
      op = ops[$urandom_range(0, 8)];
      a = ($urandom_range(0, 3) == 0) ? esp[$urandom_range(0, 4)] : W'($urandom);
      b = ($urandom_range(0, 3) == 0) ? esp[$urandom_range(0, 4)] : W'($urandom >> $urandom_range(0, 31));
      ref_model(op, a, b, exp_out, exp_lat);
      do_op(op, a, b, (i % 3) == 0, lat);
      n_cmp++; if (lat !== exp_lat) begin n_bad++; $display("FAIL rand_lat[%0d] op %0d: got %0d want %0d", i, op, lat, exp_lat); end
      n_cmp++; if (obs() !== exp_out) begin n_bad++; $display("FAIL rand_res[%0d] op %0d a %h b %h: got %h want %h", i, op, a, b, obs(), exp_out); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
